// File: rtl/burst_sram_pkg.sv
// Shared bus field widths, FSM state type and byte-lane helper for the burst SSRAM slave.
package burst_sram_pkg;

  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned BUS_WIDTH   = 8 * WORD_BYTES;
  localparam int unsigned BE_WIDTH    = WORD_BYTES;
  localparam int unsigned BURST_WIDTH = 8;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ERROR    = 4'd1,
    RD_FETCH = 4'd2,
    RD_BURST = 4'd3,
    RD_END   = 4'd4,
    WRITE    = 4'd5
  } busState_t;

  function automatic logic [BUS_WIDTH-1:0] laneMask(input logic [BE_WIDTH-1:0] byteEnables);
    logic [BUS_WIDTH-1:0] mask;
    mask = '0;
    for (int unsigned lane = 0; lane < BE_WIDTH; lane++) begin
      mask[lane*8 +: 8] = {8{byteEnables[lane]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dualPortSSRAM.sv
// Synchronous dual-port RAM: port A read/masked-write, port B read-only.
module dualPortSSRAM #(
  parameter int unsigned bitwidth    = 32,
  parameter int unsigned nrOfEntries = 512
) (
  input  logic                           clockA,
  input  logic                           writeEnableA,
  input  logic [$clog2(nrOfEntries)-1:0] addressA,
  input  logic [bitwidth-1:0]            dataInA,
  input  logic [bitwidth-1:0]            writeMaskA,
  output logic [bitwidth-1:0]            dataOutA,
  input  logic                           clockB,
  input  logic [$clog2(nrOfEntries)-1:0] addressB,
  output logic [bitwidth-1:0]            dataOutB
);

  logic [bitwidth-1:0] memory [nrOfEntries];

  // Masked bits keep their stored value, so partial-word writes merge in place.
  always_ff @(posedge clockA) begin
    if (writeEnableA) begin
      memory[addressA] <= (memory[addressA] & ~writeMaskA) | (dataInA & writeMaskA);
    end
    dataOutA <= memory[addressA];
  end

  always_ff @(posedge clockB) begin
    dataOutB <= memory[addressB];
  end

endmodule

// File: rtl/burst_sram_slave.sv
// Burst-capable OR-bus slave in front of an on-chip SSRAM window.
module burst_sram_slave
  import burst_sram_pkg::*;
#(
  parameter logic [31:0] baseAddress      = 32'h5000_0000,
  parameter int unsigned addressBits      = 10,
  parameter int unsigned writeStallPeriod = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  output logic        endTransactionOut,
  output logic        dataValidOut,
  output logic        busyOut,
  output logic        busErrorOut,
  output logic [31:0] addressDataOut
);

  localparam int unsigned LAST_INDEX   = (1 << addressBits) - 1;
  localparam logic [15:0] STALL_PERIOD = 16'(writeStallPeriod);

  busState_t              state;
  logic [addressBits-1:0] wordIndex;
  logic [7:0]             wordCount;
  logic [3:0]             byteEnables;
  logic                   writesDone;
  logic [15:0]            stallCount;

  logic                   hit;
  logic [addressBits-1:0] beginIndex;
  logic [31:0]            lastWordIndex;
  logic                   rangeError;
  logic                   wordAccept;
  logic                   ramWrite;
  logic [addressBits-1:0] ramAddress;
  logic [31:0]            writeMask;
  logic [31:0]            ramReadData;
  logic [31:0]            unusedDebugData;

  always_comb begin
    hit           = addressDataIn[31:addressBits+2] == baseAddress[31:addressBits+2];
    beginIndex    = addressDataIn[addressBits+1:2];
    lastWordIndex = 32'(beginIndex) + 32'(burstSizeIn);
    rangeError    = lastWordIndex > LAST_INDEX;
    wordAccept    = (state == WRITE) && dataValidIn && !busyOut && !writesDone && !endTransactionIn;
    ramWrite      = wordAccept && !reset;
    // The first read word is fetched straight from the begin-cycle address so
    // that data can leave from a register two cycles after the begin cycle.
    ramAddress    = (state == IDLE) ? beginIndex : wordIndex;
    writeMask     = laneMask(byteEnables);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      wordIndex         <= '0;
      wordCount         <= '0;
      byteEnables       <= '0;
      writesDone        <= 1'b0;
      stallCount        <= '0;
      endTransactionOut <= 1'b0;
      dataValidOut      <= 1'b0;
      busyOut           <= 1'b0;
      busErrorOut       <= 1'b0;
      addressDataOut    <= '0;
    end else begin
      endTransactionOut <= 1'b0;
      dataValidOut      <= 1'b0;
      busyOut           <= 1'b0;
      busErrorOut       <= 1'b0;
      addressDataOut    <= '0;
      unique case (state)
        IDLE: begin
          if (beginTransactionIn && hit) begin
            wordIndex   <= readNotWriteIn ? beginIndex + addressBits'(1) : beginIndex;
            wordCount   <= burstSizeIn;
            byteEnables <= byteEnablesIn;
            writesDone  <= 1'b0;
            stallCount  <= '0;
            if (rangeError) begin
              state             <= ERROR;
              busErrorOut       <= 1'b1;
              endTransactionOut <= 1'b1;
            end else if (readNotWriteIn) begin
              state <= RD_FETCH;
            end else begin
              state <= WRITE;
            end
          end
        end
        ERROR: state <= IDLE;
        RD_FETCH: begin
          if (endTransactionIn) begin
            state <= IDLE;
          end else begin
            dataValidOut   <= 1'b1;
            addressDataOut <= ramReadData & writeMask;
            wordIndex      <= wordIndex + addressBits'(1);
            state          <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (endTransactionIn) begin
            state <= IDLE;
          end else if (wordCount == '0) begin
            endTransactionOut <= 1'b1;
            state             <= RD_END;
          end else begin
            dataValidOut   <= 1'b1;
            addressDataOut <= ramReadData & writeMask;
            wordIndex      <= wordIndex + addressBits'(1);
            wordCount      <= wordCount - 8'd1;
          end
        end
        RD_END: state <= IDLE;
        WRITE: begin
          if (endTransactionIn) begin
            state <= IDLE;
          end else if (wordAccept) begin
            wordIndex <= wordIndex + addressBits'(1);
            if (wordCount == '0) writesDone <= 1'b1;
            else                 wordCount  <= wordCount - 8'd1;
            if (STALL_PERIOD != '0) begin
              if (stallCount + 16'd1 == STALL_PERIOD) begin
                busyOut    <= 1'b1;
                stallCount <= '0;
              end else begin
                stallCount <= stallCount + 16'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dualPortSSRAM #(
    .bitwidth   (32),
    .nrOfEntries(1 << addressBits)
  ) sram (
    .clockA      (clock),
    .writeEnableA(ramWrite),
    .addressA    (ramAddress),
    .dataInA     (addressDataIn),
    .writeMaskA  (writeMask),
    .dataOutA    (ramReadData),
    .clockB      (clock),
    .addressB    ('0),
    .dataOutB    (unusedDebugData)
  );

endmodule

// File: tb/tb_burst_sram_slave.sv
// Randomized bench for burst_sram_slave against a word-array memory model of the bus protocol.
module tb_burst_sram_slave;

  localparam logic [31:0] BASE  = 32'h5000_0000;
  localparam int unsigned AB    = 10;
  localparam int unsigned DEPTH = 1 << AB;
  localparam int unsigned STALL = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn;
  logic [31:0] addressDataIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        endTransactionOut, dataValidOut, busyOut, busErrorOut;
  logic [31:0] addressDataOut;

  int unsigned testCount = 0;
  int unsigned failCount = 0;
  logic [31:0] refMem [DEPTH];
  logic [31:0] wrData [264];

  burst_sram_slave #(
    .baseAddress     (BASE),
    .addressBits     (AB),
    .writeStallPeriod(STALL)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .readNotWriteIn    (readNotWriteIn),
    .dataValidIn       (dataValidIn),
    .addressDataIn     (addressDataIn),
    .byteEnablesIn     (byteEnablesIn),
    .burstSizeIn       (burstSizeIn),
    .endTransactionOut (endTransactionOut),
    .dataValidOut      (dataValidOut),
    .busyOut           (busyOut),
    .busErrorOut       (busErrorOut),
    .addressDataOut    (addressDataOut)
  );

  always #5 clock = ~clock;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", testCount, failCount);
    $fatal(1, "watchdog");
  end

  task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] busNow();
    return {28'd0, endTransactionOut, dataValidOut, busyOut, busErrorOut, addressDataOut};
  endfunction

  function automatic logic [63:0] expBus(input logic e, input logic v, input logic b, input logic err,
                                         input logic [31:0] d);
    return {28'd0, e, v, b, err, d};
  endfunction

  function automatic logic [31:0] maskOf(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic inWindow(input logic [31:0] addr);
    logic [31:0] b;
    b = BASE;
    return addr[31:AB+2] == b[31:AB+2];
  endfunction

  function automatic int unsigned indexOf(input logic [31:0] addr);
    return int'(addr[AB+1:2]);
  endfunction

  task automatic idleInputs();
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b0;
    readNotWriteIn     = 1'b0;
    dataValidIn        = 1'b0;
    addressDataIn      = '0;
    byteEnablesIn      = '0;
    burstSizeIn        = '0;
  endtask

  // Ends at the negedge of the first cycle after the begin cycle.
  task automatic startBus(input logic [31:0] addr, input logic rnw, input logic [3:0] be, input int unsigned burst);
    @(negedge clock);
    beginTransactionIn = 1'b1;
    readNotWriteIn     = rnw;
    addressDataIn      = addr;
    byteEnablesIn      = be;
    burstSizeIn        = 8'(burst);
    @(negedge clock);
    idleInputs();
  endtask

  task automatic expectQuiet(input string tag, input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      checkValue(tag, busNow(), 64'd0);
      @(negedge clock);
    end
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [3:0] be, input int unsigned burst,
                          input int unsigned sendWords);
    int unsigned idx, sent, stored, guard;
    logic        lastStored, busySeen, expBusy;
    logic [31:0] m;
    idx = indexOf(addr);
    m   = maskOf(be);
    startBus(addr, 1'b0, be, burst);
    if (!inWindow(addr)) begin
      expectQuiet("wr_miss", 3);
      return;
    end
    if (idx + burst > DEPTH - 1) begin
      checkValue("wr_err", busNow(), expBus(1'b1, 1'b0, 1'b0, 1'b1, 32'd0));
      @(negedge clock);
      expectQuiet("wr_err_after", 2);
      return;
    end
    sent = 0; stored = 0; guard = 0; lastStored = 1'b0;
    while (sent < sendWords && guard < 4 * sendWords + 8) begin
      busySeen = busyOut;
      expBusy  = lastStored && (stored % STALL == 0);
      checkValue("wr_bus", busNow(), expBus(1'b0, 1'b0, expBusy, 1'b0, 32'd0));
      dataValidIn   = 1'b1;
      addressDataIn = wrData[sent];
      @(negedge clock);
      guard++;
      lastStored = 1'b0;
      if (!busySeen) begin
        if (stored <= burst) begin
          refMem[idx + stored] = (refMem[idx + stored] & ~m) | (wrData[sent] & m);
          stored++;
          lastStored = 1'b1;
        end
        sent++;
      end
    end
    checkValue("wr_sent", 64'(sent), 64'(sendWords));
    dataValidIn   = 1'b0;
    addressDataIn = '0;
    expBusy = lastStored && (stored % STALL == 0);
    checkValue("wr_tail", busNow(), expBus(1'b0, 1'b0, expBusy, 1'b0, 32'd0));
    endTransactionIn = 1'b1;
    @(negedge clock);
    endTransactionIn = 1'b0;
    expectQuiet("wr_end", 1);
  endtask

  task automatic busRead(input logic [31:0] addr, input logic [3:0] be, input int unsigned burst, input int abortAt);
    int unsigned idx;
    logic [31:0] m;
    idx = indexOf(addr);
    m   = maskOf(be);
    startBus(addr, 1'b1, be, burst);
    if (!inWindow(addr)) begin
      expectQuiet("rd_miss", 3);
      return;
    end
    if (idx + burst > DEPTH - 1) begin
      checkValue("rd_err", busNow(), expBus(1'b1, 1'b0, 1'b0, 1'b1, 32'd0));
      @(negedge clock);
      expectQuiet("rd_err_after", 2);
      return;
    end
    checkValue("rd_fetch", busNow(), 64'd0);
    for (int k = 0; k <= int'(burst); k++) begin
      @(negedge clock);
      checkValue("rd_data", busNow(), expBus(1'b0, 1'b1, 1'b0, 1'b0, refMem[idx + k] & m));
      if (k == abortAt) begin
        endTransactionIn = 1'b1;
        @(negedge clock);
        endTransactionIn = 1'b0;
        expectQuiet("rd_abort", 3);
        return;
      end
    end
    @(negedge clock);
    checkValue("rd_end", busNow(), expBus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0));
    @(negedge clock);
    expectQuiet("rd_idle", 2);
  endtask

  int unsigned kind, burst, idx, sendWords;
  int          abortAt;
  logic [3:0]  be;
  logic [31:0] addr;

  initial begin
    idleInputs();
    repeat (3) @(negedge clock);
    checkValue("reset", busNow(), 64'd0);
    reset = 1'b0;

    for (int unsigned blk = 0; blk < 4; blk++) begin
      for (int unsigned w = 0; w < 256; w++) wrData[w] = $urandom;
      busWrite(BASE + 32'(blk * 1024), 4'hF, 255, 256);
    end

    // Directed: aligned burst write and read-back.
    for (int unsigned w = 0; w < 4; w++) wrData[w] = 32'(w + 1);
    busWrite(BASE + 32'h10, 4'hF, 3, 4);
    busRead(BASE + 32'h10, 4'hF, 3, -1);
    checkValue("t1_word7", 64'(refMem[7]), 64'd4);

    // Directed: byte-lane merge.
    wrData[0] = 32'hFFFF_FFFF;
    busWrite(BASE + 32'd80, 4'hF, 0, 1);
    wrData[0] = 32'hAABB_CCDD;
    busWrite(BASE + 32'd80, 4'b0011, 0, 1);
    busRead(BASE + 32'd80, 4'hF, 0, -1);
    checkValue("t2_model", 64'(refMem[20]), 64'hFFFF_CCDD);

    // Directed: stalled 6-word write, window-end error, misses, abort.
    for (int unsigned w = 0; w < 6; w++) wrData[w] = 32'hC0DE_0000 + 32'(w);
    busWrite(BASE + 32'd160, 4'hF, 5, 6);
    busRead(BASE + 32'd160, 4'hF, 5, -1);
    busRead(BASE + 32'(1022 * 4), 4'hF, 2, -1);
    busWrite(BASE + 32'(1020 * 4), 4'hF, 7, 0);
    busRead(BASE + 32'(1016 * 4), 4'hF, 7, -1);
    busRead(32'h6000_0040, 4'hF, 3, -1);
    busWrite(32'h4FFF_FFF0, 4'hF, 0, 0);
    busRead(BASE + 32'd400, 4'hF, 7, 2);

    // Directed: reset in the middle of a write burst.
    startBus(BASE + 32'(900 * 4), 1'b0, 4'hF, 7);
    dataValidIn   = 1'b1;
    addressDataIn = 32'h1111_0001;
    @(negedge clock);
    addressDataIn = 32'h1111_0002;
    @(negedge clock);
    checkValue("rst_busy", busNow(), expBus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0));
    dataValidIn = 1'b0;
    reset       = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkValue("rst_mid", busNow(), 64'd0);
    refMem[900] = 32'h1111_0001;
    refMem[901] = 32'h1111_0002;
    busRead(BASE + 32'(900 * 4), 4'hF, 2, -1);

    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 9);
      burst = $urandom_range(0, 15);
      idx   = $urandom_range(0, DEPTH - 1 - burst);
      be    = 4'($urandom_range(1, 15));
      addr  = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      if (kind < 4) begin
        for (int unsigned w = 0; w < 20; w++) wrData[w] = $urandom;
        sendWords = ($urandom_range(0, 3) == 0) ? $urandom_range(1, burst + 3) : burst + 1;
        busWrite(addr, be, burst, sendWords);
      end else if (kind < 8) begin
        abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, burst)) : -1;
        busRead(addr, be, burst, abortAt);
      end else if (kind == 8) begin
        burst = $urandom_range(1, 40);
        idx   = $urandom_range(DEPTH - burst, DEPTH - 1);
        addr  = BASE + 32'(idx * 4);
        if ($urandom_range(0, 1) == 1) busRead(addr, be, burst, -1);
        else                           busWrite(addr, be, burst, 0);
      end else begin
        addr = $urandom;
        if (inWindow(addr)) addr = addr ^ 32'h8000_0000;
        if ($urandom_range(0, 1) == 1) busRead(addr, be, burst, -1);
        else                           busWrite(addr, be, burst, 0);
      end
    end

    for (int unsigned blk = 0; blk < 4; blk++) begin
      busRead(BASE + 32'(blk * 1024), 4'hF, 255, -1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
